// File: rtl/countdown_hms_04.sv
// BCD HH:MM:SS countdown timer.
// Loaded with a BCD time, it decrements once per 1 Hz tick while running and
// pulses done_04 when the count reaches 00:00:00.
// Ports:
//   clk_04       system clock
//   rst_04       synchronous active-high reset
//   tick_04      one-cycle 1 Hz strobe
//   load_04      load load_val_04 (checked for legality)
//   load_val_04  BCD H1 H0 M1 M0 S1 S0, [23:20] .. [3:0]
//   start_04     start / resume
//   pause_04     pause
//   dout_04      current BCD value, same packing as load_val_04
//   running_04   high while in RUN
//   done_04      one-cycle pulse on reaching 00:00:00
//   err_04       one-cycle pulse when a load is rejected
module countdown_hms_04 #(
    parameter int unsigned HOUR_MAX_TENS         = 2,
    parameter int unsigned HOUR_MAX_UNITS_AT_TOP = 3
) (
    input  logic        clk_04,
    input  logic        rst_04,
    input  logic        tick_04,
    input  logic        load_04,
    input  logic [23:0] load_val_04,
    input  logic        start_04,
    input  logic        pause_04,
    output logic [23:0] dout_04,
    output logic        running_04,
    output logic        done_04,
    output logic        err_04
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned TIME_W  = 24;

    localparam logic [DIGIT_W-1:0] H1_MAX = DIGIT_W'(HOUR_MAX_TENS);
    localparam logic [DIGIT_W-1:0] H0_TOP = DIGIT_W'(HOUR_MAX_UNITS_AT_TOP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t state;

    logic              load_ok_c;
    logic [TIME_W-1:0] dec_val_c;

    // Load legality: BCD digits, tens of minutes/seconds <= 5, hours <= 23.
    always_comb begin
        load_ok_c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (load_val_04[i*4 +: 4] > 4'd9) begin
                load_ok_c = 1'b0;
            end
        end
        if (load_val_04[7:4] > 4'd5 || load_val_04[15:12] > 4'd5) begin
            load_ok_c = 1'b0;
        end
        if (load_val_04[23:20] > H1_MAX) begin
            load_ok_c = 1'b0;
        end else if (load_val_04[23:20] == H1_MAX && load_val_04[19:16] > H0_TOP) begin
            load_ok_c = 1'b0;
        end
    end

    // One-second decrement with borrow rippling S0 -> S1 -> M0 -> M1 -> H0 -> H1.
    // H1 never underflows because a zero count is never decremented.
    always_comb begin
        logic             borrow;
        logic [DIGIT_W-1:0] wrap;
        dec_val_c = dout_04;
        borrow    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wrap = (i == 1 || i == 3) ? 4'd5 : 4'd9;
            if (borrow) begin
                if (i == 5) begin
                    dec_val_c[i*4 +: 4] = dout_04[i*4 +: 4] - 4'd1;
                    borrow = 1'b0;
                end else if (dout_04[i*4 +: 4] == 4'd0) begin
                    dec_val_c[i*4 +: 4] = wrap;
                end else begin
                    dec_val_c[i*4 +: 4] = dout_04[i*4 +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Control FSM and output registers; priority reset > load > start/pause > tick.
    always_ff @(posedge clk_04) begin
        if (rst_04) begin
            state      <= ST_IDLE;
            dout_04    <= '0;
            running_04 <= 1'b0;
            done_04    <= 1'b0;
            err_04     <= 1'b0;
        end else begin
            done_04 <= 1'b0;
            err_04  <= 1'b0;
            if (load_04) begin
                if (load_ok_c) begin
                    dout_04    <= load_val_04;
                    state      <= ST_IDLE;
                    running_04 <= 1'b0;
                end else begin
                    err_04 <= 1'b1;
                end
            end else if (start_04 && pause_04) begin
                // Conflicting commands: hold state, and the tick is dropped.
            end else if (start_04) begin
                if ((state == ST_IDLE && dout_04 != '0) || state == ST_PAUSE) begin
                    state      <= ST_RUN;
                    running_04 <= 1'b1;
                end
            end else if (pause_04) begin
                if (state == ST_RUN) begin
                    state      <= ST_PAUSE;
                    running_04 <= 1'b0;
                end
            end else if (tick_04 && state == ST_RUN) begin
                dout_04 <= dec_val_c;
                if (dec_val_c == '0) begin
                    done_04    <= 1'b1;
                    state      <= ST_IDLE;
                    running_04 <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_hms_04.sv
// Directed testbench for countdown_hms_04 with hand-computed expectations.
module tb_countdown_hms_04;

    logic        clk_04 = 1'b0;
    logic        rst_04 = 1'b0;
    logic        tick_04 = 1'b0;
    logic        load_04 = 1'b0;
    logic [23:0] load_val_04 = '0;
    logic        start_04 = 1'b0;
    logic        pause_04 = 1'b0;
    logic [23:0] dout_04;
    logic        running_04;
    logic        done_04;
    logic        err_04;

    int n_cmp = 0;
    int n_err = 0;

    countdown_hms_04 #(
        .HOUR_MAX_TENS        (2),
        .HOUR_MAX_UNITS_AT_TOP(3)
    ) dut (
        .clk_04     (clk_04),
        .rst_04     (rst_04),
        .tick_04    (tick_04),
        .load_04    (load_04),
        .load_val_04(load_val_04),
        .start_04   (start_04),
        .pause_04   (pause_04),
        .dout_04    (dout_04),
        .running_04 (running_04),
        .done_04    (done_04),
        .err_04     (err_04)
    );

    always #5 clk_04 = ~clk_04;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk_04);
        #1;
    endtask

    task automatic do_load(input logic [23:0] v);
        load_04 = 1'b1; load_val_04 = v; cyc(); load_04 = 1'b0;
    endtask

    task automatic do_start();
        start_04 = 1'b1; cyc(); start_04 = 1'b0;
    endtask

    task automatic do_pause();
        pause_04 = 1'b1; cyc(); pause_04 = 1'b0;
    endtask

    task automatic do_tick();
        tick_04 = 1'b1; cyc(); tick_04 = 1'b0;
    endtask

    initial begin
        // 1: reset, then count 00:00:03 down to zero
        rst_04 = 1'b1; cyc(); cyc(); rst_04 = 1'b0;
        chk("rst_dout", dout_04, 24'h000000);
        chk("rst_run", 24'(running_04), 24'd0);
        chk("rst_done", 24'(done_04), 24'd0);
        chk("rst_err", 24'(err_04), 24'd0);
        do_load(24'h000003);
        chk("t1_load", dout_04, 24'h000003);
        do_start();
        chk("t1_run", 24'(running_04), 24'd1);
        do_tick();
        chk("t1_tick1", dout_04, 24'h000002);
        chk("t1_nodone1", 24'(done_04), 24'd0);
        repeat (4) cyc();
        do_tick();
        chk("t1_tick2", dout_04, 24'h000001);
        repeat (4) cyc();
        do_tick();
        chk("t1_tick3", dout_04, 24'h000000);
        chk("t1_done", 24'(done_04), 24'd1);
        chk("t1_runfall", 24'(running_04), 24'd0);
        cyc();
        chk("t1_done_1cyc", 24'(done_04), 24'd0);

        // 2: full borrow ripple
        do_load(24'h010000);
        do_start();
        do_tick();
        chk("t2_ripple", dout_04, 24'h005959);
        do_tick();
        chk("t2_tick2", dout_04, 24'h005958);
        do_load(24'h100000);
        do_start();
        do_tick();
        chk("t2_h1borrow", dout_04, 24'h095959);

        // 3: load legality
        do_load(24'h235959);
        chk("t3_max", dout_04, 24'h235959);
        chk("t3_max_err", 24'(err_04), 24'd0);
        chk("t3_idle", 24'(running_04), 24'd0);
        do_load(24'h240000);
        chk("t3_h24_err", 24'(err_04), 24'd1);
        chk("t3_h24_dout", dout_04, 24'h235959);
        cyc();
        chk("t3_err_1cyc", 24'(err_04), 24'd0);
        do_load(24'h006000);
        chk("t3_m60_err", 24'(err_04), 24'd1);
        cyc();
        do_load(24'h000A00);
        chk("t3_hex_err", 24'(err_04), 24'd1);
        chk("t3_hex_dout", dout_04, 24'h235959);
        cyc();

        // 4: pause / resume
        do_load(24'h000010);
        do_start();
        do_tick();
        chk("t4_tick", dout_04, 24'h000009);
        do_pause();
        chk("t4_paused", 24'(running_04), 24'd0);
        repeat (3) begin do_tick(); cyc(); end
        chk("t4_hold", dout_04, 24'h000009);
        chk("t4_hold_run", 24'(running_04), 24'd0);
        do_start();
        chk("t4_resume", 24'(running_04), 24'd1);
        do_tick();
        chk("t4_tick2", dout_04, 24'h000008);

        // 5: start at zero ignored; start+pause together does nothing
        do_load(24'h000000);
        do_start();
        chk("t5_zero_start", 24'(running_04), 24'd0);
        chk("t5_zero_done", 24'(done_04), 24'd0);
        do_load(24'h000005);
        start_04 = 1'b1; pause_04 = 1'b1; cyc(); start_04 = 1'b0; pause_04 = 1'b0;
        chk("t5_both_idle", 24'(running_04), 24'd0);
        do_tick();
        chk("t5_idle_tick", dout_04, 24'h000005);
        do_start();
        start_04 = 1'b1; pause_04 = 1'b1; tick_04 = 1'b1; cyc();
        start_04 = 1'b0; pause_04 = 1'b0; tick_04 = 1'b0;
        chk("t5_both_run", 24'(running_04), 24'd1);
        chk("t5_both_tick", dout_04, 24'h000005);
        // tick coinciding with the entering start is not applied
        do_load(24'h000005);
        start_04 = 1'b1; tick_04 = 1'b1; cyc(); start_04 = 1'b0; tick_04 = 1'b0;
        chk("t5_start_tick", dout_04, 24'h000005);
        chk("t5_start_run", 24'(running_04), 24'd1);

        // 6: reset mid-count, and load during RUN drops the tick
        do_load(24'h000500);
        do_start();
        rst_04 = 1'b1; tick_04 = 1'b1; cyc(); rst_04 = 1'b0; tick_04 = 1'b0;
        chk("t6_rst_dout", dout_04, 24'h000000);
        chk("t6_rst_run", 24'(running_04), 24'd0);
        chk("t6_rst_done", 24'(done_04), 24'd0);
        do_load(24'h000500);
        do_start();
        do_tick();
        chk("t6_tick", dout_04, 24'h000459);
        load_04 = 1'b1; load_val_04 = 24'h001000; tick_04 = 1'b1; cyc();
        load_04 = 1'b0; tick_04 = 1'b0;
        chk("t6_load_run", dout_04, 24'h001000);
        chk("t6_load_idle", 24'(running_04), 24'd0);
        do_tick();
        chk("t6_idle_tick", dout_04, 24'h001000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
